fifo_byte_reader: RTL and testbench
===================================

// Module: fifo_byte_reader
// PURPOSE
//  - Consumer at the read end of the 32-bit word FIFO: pops words through the FIFO's rd/empty/data_out
//    interface and emits each one as DATA_W/8 bytes on a valid/ready byte stream.
//  - Sits between the word FIFO and any byte-wide sink (UART TX, byte bus bridge).
//  - Counts completed words for software/debug visibility.
// PARAMETERS
//  DATA_W     32  FIFO word width; must be a multiple of 8 (BYTES = DATA_W/8)
//  MSB_FIRST  1   1: bits [DATA_W-1 -: 8] go out first; 0: bits [7:0] go out first
//  CNT_W      16  width of word_count
// PORTS
//  clk          in   1        single clock; all logic on posedge clk
//  reset        in   1        asynchronous, active-low reset (0 = reset asserted)
//  enable       in   1        1: allowed to start popping new words
//  fifo_empty   in   1        FIFO empty flag
//  fifo_data    in   DATA_W   FIFO data_out; valid on the cycle after the rd pulse
//  fifo_rd      out  1        FIFO read strobe, one cycle per word
//  m_data       out  8        current output byte
//  m_valid      out  1        m_data valid
//  m_ready      in   1        sink accepts byte when m_valid && m_ready at posedge clk
//  busy         out  1        1 whenever state != IDLE
//  word_count   out  CNT_W    number of words fully transmitted, wraps modulo 2^CNT_W
// BEHAVIOUR
//  - Reset (reset==0, asynchronous): state=IDLE, shift reg=0, byte_idx=0, word_count=0;
//    fifo_rd=0, m_valid=0, m_data=0, busy=0. A partially sent word is discarded and never resumed.
//  - FSM states are IDLE, LOAD and SEND.
//    IDLE: fifo_rd = enable && !fifo_empty (combinational). If fifo_rd=1, next state is LOAD.
//    LOAD: the FIFO has updated data_out. Capture fifo_data into the shift reg, set byte_idx=0, go to SEND.
//      fifo_rd=0 and m_valid=0 in this state.
//    SEND: m_valid=1 and m_data=byte[byte_idx], ordered per MSB_FIRST.
//      On m_valid && m_ready: if byte_idx==BYTES-1, increment word_count and go to IDLE;
//      otherwise byte_idx+1 and stay in SEND.
//  - m_data and m_valid are registered outputs. m_data is stable while m_valid && !m_ready (AXI-style hold).
//  - Latency is 2 cycles from fifo_rd to the first m_valid. Best case is BYTES+2 cycles per word (6 for 32b).
//  - fifo_rd is never asserted while fifo_empty=1. fifo_rd is never asserted outside IDLE, so at most one
//    word is in flight.
//  - enable dropping in LOAD or SEND: the current word completes normally, and no new pop starts until
//    enable=1.
//  - fifo_empty rising in LOAD or SEND has no effect, because the word is already captured.
//  - m_ready held low: the FSM stalls in SEND indefinitely with no FIFO activity.
//  - word_count wraps from 2^CNT_W-1 to 0 with no flag.
//  - busy = (state != IDLE).
// CONFIGURATION
//  FIFO_READER_PARITY_EN defined:
//    - Adds output port m_parity (1 bit), registered alongside m_data.
//    - m_parity = ~^m_data (odd parity) and is valid with m_valid. Its reset value is 1 (odd parity of 0x00).
//  Not defined: m_parity does not exist. No other behaviour changes.
// TESTING
//  1. Hold reset=0 for 3 cycles, then release -> all outputs 0, busy=0, word_count=0, no fifo_rd.
//  2. Pop one word 0xA1B2C3D4 with m_ready=1 and MSB_FIRST=1 -> fifo_rd pulses for 1 cycle.
//     Bytes A1,B2,C3,D4 appear on 4 consecutive cycles starting 2 cycles after fifo_rd.
//     word_count then reads 1 and busy=0.
//  3. Same word with MSB_FIRST=0, and m_ready low for 3 cycles on byte 2 -> order is D4,C3,B2,A1.
//     m_data holds C3 during the stall. No extra fifo_rd.
//  4. Preload FIFO with 8 words, enable=1, m_ready=1 -> exactly 8 fifo_rd pulses and 32 bytes in order.
//     fifo_rd is never asserted once fifo_empty=1. word_count=8.
//  5. Drop enable during byte 1 of word 3 -> word 3 finishes, then no fifo_rd.
//     Re-raise enable -> popping resumes with word 4.
//  6. Assert reset during byte 2 -> outputs go to reset values immediately (asynchronously).
//     After release, the next word comes from a fresh pop with byte_idx=0.
//     With FIFO_READER_PARITY_EN defined: byte 0x07 gives m_parity=0 and byte 0x03 gives m_parity=1.

Source files
------------

// File: rtl/fifo_byte_reader.sv
// Pops DATA_W-bit words from a word FIFO and streams them out as bytes on a valid/ready interface.
// Optional odd-parity output m_parity when FIFO_READER_PARITY_EN is defined.
module fifo_byte_reader #(
  parameter int DATA_W    = 32,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic [7:0]        m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
`ifdef FIFO_READER_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] shift_reg;
  logic [IDX_W-1:0]  byte_idx;
  logic              accept;
  logic              last_byte;
  logic              load_byte;
  logic [7:0]        next_byte;

  function automatic logic [7:0] pick_byte(input logic [DATA_W-1:0] word,
                                           input logic [IDX_W-1:0]  idx);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < BYTES; i++) begin
      if (IDX_W'(i) == idx) begin
        b = (MSB_FIRST != 0) ? word[DATA_W-1-8*i -: 8] : word[8*i +: 8];
      end
    end
    return b;
  endfunction

  // Reset gates the strobe so no word is popped while the block is held in reset.
  assign fifo_rd   = reset && (state == IDLE) && enable && !fifo_empty;
  assign busy      = (state != IDLE);
  assign accept    = m_valid && m_ready;
  assign last_byte = (byte_idx == IDX_W'(BYTES - 1));
  assign load_byte = (state == LOAD) || ((state == SEND) && accept && !last_byte);
  assign next_byte = (state == LOAD) ? pick_byte(fifo_data, '0)
                                     : pick_byte(shift_reg, byte_idx + 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      byte_idx   <= '0;
      word_count <= '0;
      m_valid    <= 1'b0;
      m_data     <= '0;
    end else begin
      if (load_byte) begin
        m_data <= next_byte;
      end
      case (state)
        IDLE: begin
          if (fifo_rd) begin
            state <= LOAD;
          end
        end
        LOAD: begin
          shift_reg <= fifo_data;
          byte_idx  <= '0;
          m_valid   <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (accept) begin
            if (last_byte) begin
              m_valid    <= 1'b0;
              word_count <= word_count + 1'b1;
              state      <= IDLE;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef FIFO_READER_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_parity <= 1'b1;
    end else if (load_byte) begin
      m_parity <= ~^next_byte;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_byte_reader.sv
// Bench for fifo_byte_reader: MSB-first and LSB-first instances share one FIFO model and stimulus.
// Expected bytes are queued when words are written into the FIFO model and popped on each handshake.
module tb_fifo_byte_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        m_ready;
  logic [31:0] fifo_data = '0;
  logic        fifo_empty;
  logic        fifo_rd_a, fifo_rd_b;
  logic [7:0]  m_data_a, m_data_b;
  logic        m_valid_a, m_valid_b;
  logic        busy_a, busy_b;
  logic [15:0] word_count_a;
  logic [3:0]  word_count_b;
`ifdef FIFO_READER_PARITY_EN
  logic        m_parity_a, m_parity_b;
`endif

  always #5 clk = ~clk;

  fifo_byte_reader #(.DATA_W(32), .MSB_FIRST(1), .CNT_W(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd_a), .m_data(m_data_a), .m_valid(m_valid_a), .m_ready(m_ready),
    .busy(busy_a), .word_count(word_count_a)
`ifdef FIFO_READER_PARITY_EN
    , .m_parity(m_parity_a)
`endif
  );

  fifo_byte_reader #(.DATA_W(32), .MSB_FIRST(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd_b), .m_data(m_data_b), .m_valid(m_valid_b), .m_ready(m_ready),
    .busy(busy_b), .word_count(word_count_b)
`ifdef FIFO_READER_PARITY_EN
    , .m_parity(m_parity_b)
`endif
  );

  // FIFO model: data_out updates on the edge that samples fifo_rd.
  logic [31:0] mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int rd_cnt = 0;
  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (fifo_rd_a || fifo_rd_b) begin
      checks++;
      if (fifo_empty) begin
        errors++;
        $display("FAIL rd_when_empty: fifo_rd=1 while fifo_empty=1, required 0");
      end
      checks++;
      if (fifo_rd_a !== fifo_rd_b) begin
        errors++;
        $display("FAIL rd_match: fifo_rd_a=%0b fifo_rd_b=%0b, required equal", fifo_rd_a, fifo_rd_b);
      end
      if (!fifo_empty) begin
        fifo_data <= mem[rd_ptr[7:0]];
        rd_ptr    <= rd_ptr + 1;
      end
      rd_cnt <= rd_cnt + 1;
    end
  end

  typedef struct {
    logic [31:0] word;
    int          stall_idx;
    int          stall_len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
    for (int i = 0; i < 4; i++) begin
      exp_a.push_back(w[31-8*i -: 8]);
      exp_b.push_back(w[8*i +: 8]);
    end
  endtask

  task automatic wait_valid(output int waited);
    int t;
    t = 0;
    while (!m_valid_a && t < 50) begin
      @(negedge clk);
      t++;
    end
    waited = t;
    if (!m_valid_a) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: m_valid=0 after 50 cycles, required 1");
    end
  endtask

  task automatic take_byte(input int stall, output int waited);
    logic [7:0] ea, eb;
    wait_valid(waited);
    if (!m_valid_a) return;
    if (exp_a.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL extra_byte: got 0x%0h with empty scoreboard, required no byte", m_data_a);
      return;
    end
    ea = exp_a.pop_front();
    eb = exp_b.pop_front();
    for (int s = 0; s < stall; s++) begin
      m_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", {31'b0, m_valid_a}, 32'd1);
      chk("hold_data_a", {24'b0, m_data_a}, {24'b0, ea});
      chk("hold_data_b", {24'b0, m_data_b}, {24'b0, eb});
    end
    m_ready = 1'b1;
    chk("valid_b", {31'b0, m_valid_b}, 32'd1);
    chk("byte_a", {24'b0, m_data_a}, {24'b0, ea});
    chk("byte_b", {24'b0, m_data_b}, {24'b0, eb});
`ifdef FIFO_READER_PARITY_EN
    chk("parity_a", {31'b0, m_parity_a}, {31'b0, ~^ea});
    chk("parity_b", {31'b0, m_parity_b}, {31'b0, ~^eb});
`endif
    @(negedge clk);
  endtask

  task automatic finish_word();
    exp_count++;
    chk("word_count_a", {16'b0, word_count_a}, 32'(exp_count % 65536));
    chk("word_count_b", {28'b0, word_count_b}, 32'(exp_count % 16));
  endtask

  task automatic take_word(input int stall_idx, input int stall_len);
    int w;
    for (int k = 0; k < 4; k++) take_byte((k == stall_idx) ? stall_len : 0, w);
    finish_word();
  endtask

  initial begin
    int w;
    int rd0;
    vecs[0] = '{32'hA1B2C3D4, 1, 3};
    vecs[1] = '{32'h07030000, 0, 0};
    vecs[2] = '{32'hFFFFFFFF, 3, 1};
    vecs[3] = '{32'h00000000, 0, 2};
    vecs[4] = '{32'h80000001, 2, 5};
    vecs[5] = '{32'h12345678, 4, 0};

    reset = 1'b0; enable = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'b0, m_valid_a | m_valid_b}, 32'd0);
    chk("rst_data_a", {24'b0, m_data_a}, 32'd0);
    chk("rst_busy", {31'b0, busy_a | busy_b}, 32'd0);
    chk("rst_count_a", {16'b0, word_count_a}, 32'd0);
    chk("rst_rd", {31'b0, fifo_rd_a | fifo_rd_b}, 32'd0);
`ifdef FIFO_READER_PARITY_EN
    chk("rst_parity", {31'b0, m_parity_a}, 32'd1);
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy_a}, 32'd0);
    chk("idle_rd", {31'b0, fifo_rd_a}, 32'd0);

    // Single word: latency and back-to-back byte timing
    push_word(32'hA1B2C3D4);
    enable = 1'b1;
    #1;
    chk("t2_rd_pulse", {31'b0, fifo_rd_a}, 32'd1);
    @(negedge clk);
    chk("t2_load_rd", {31'b0, fifo_rd_a}, 32'd0);
    chk("t2_load_valid", {31'b0, m_valid_a}, 32'd0);
    chk("t2_load_busy", {31'b0, busy_a}, 32'd1);
    @(negedge clk);
    chk("t2_first_valid", {31'b0, m_valid_a}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      take_byte(0, w);
      chk("t2_consecutive", 32'(w), 32'd0);
    end
    finish_word();
    chk("t2_busy_done", {31'b0, busy_a}, 32'd0);
    chk("t2_rd_count", 32'(rd_cnt), 32'd1);

    for (int v = 0; v < 6; v++) begin
      rd0 = rd_cnt;
      push_word(vecs[v].word);
      take_word(vecs[v].stall_idx, vecs[v].stall_len);
      chk("vec_rd_count", 32'(rd_cnt - rd0), 32'd1);
    end

    // Eight preloaded words drained back to back
    enable = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h01020304 + 32'(i) * 32'h10101010);
    repeat (2) @(negedge clk);
    rd0 = rd_cnt;
    enable = 1'b1;
    for (int i = 0; i < 8; i++) take_word(4, 0);
    repeat (4) @(negedge clk);
    chk("t4_rd_count", 32'(rd_cnt - rd0), 32'd8);
    chk("t4_empty_busy", {31'b0, busy_a}, 32'd0);

    // enable drops during word 3
    rd0 = rd_cnt;
    for (int i = 0; i < 5; i++) push_word(32'hC0DE0000 + 32'(i));
    take_word(4, 0);
    take_word(4, 0);
    wait_valid(w);
    enable = 1'b0;
    take_word(4, 0);
    repeat (6) @(negedge clk);
    chk("t5_paused_rd", 32'(rd_cnt - rd0), 32'd3);
    chk("t5_paused_busy", {31'b0, busy_a}, 32'd0);
    enable = 1'b1;
    take_word(4, 0);
    take_word(4, 0);
    chk("t5_resumed_rd", 32'(rd_cnt - rd0), 32'd5);

    // Asynchronous reset in the middle of a word
    push_word(32'h5A6B7C8D);
    take_byte(0, w);
    take_byte(0, w);
    wait_valid(w);
    m_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, m_valid_a | m_valid_b}, 32'd0);
    chk("t6_async_data", {24'b0, m_data_a}, 32'd0);
    chk("t6_async_busy", {31'b0, busy_a}, 32'd0);
    chk("t6_async_count", {16'b0, word_count_a}, 32'd0);
`ifdef FIFO_READER_PARITY_EN
    chk("t6_async_parity", {31'b0, m_parity_a}, 32'd1);
`endif
    exp_a.delete();
    exp_b.delete();
    exp_count = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    m_ready = 1'b1;
    push_word(32'h9ABCDEF0);
    take_word(4, 0);
    chk("t6_leftover", 32'(exp_a.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
